exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order MIPS pipeline. It sits between decode (ds) and memory (ms).
- Latches the decode bus and computes ALU results through the shared alu module.
- Runs DIV/DIVU on a 32-iteration divider, owns the HI/LO registers, and serves MFHI/MFLO.
- Issues data-SRAM requests and drives the es_to_ms bus and the forwarding bus.

Parameters:
- DS_TO_ES_BUS_WD, 140, width of the decode-to-execute bus.
- ES_TO_MS_BUS_WD, 71, width of the execute-to-memory bus.
- ES_FWD_BUS_WD, 38, width of the forwarding bus.

Ports:
- clk  in  1  clock; all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- ms_allowin  in  1  ms can accept an instruction this cycle.
- es_allowin  out  1  es can accept an instruction this cycle.
- ds_to_es_valid  in  1  ds is presenting a valid instruction.
- ds_to_es_bus  in  140  field order MSB→LSB: div_op[1:0] {div,divu}, mf_op[1:0] {mfhi,mflo}, alu_op[11:0], load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0].
- es_to_ms_valid  out  1  es is handing an instruction to ms.
- es_to_ms_bus  out  71  {res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}.
- data_sram_en  out  1  data-SRAM enable.
- data_sram_wen  out  4  data-SRAM byte write enables.
- data_sram_addr  out  32  data-SRAM address.
- data_sram_wdata  out  32  data-SRAM write data.
- es_fwd_bus  out  38  {res_from_mem[37], es_result[36:5], dest masked by es_valid[4:0]}.

Behaviour:
- Reset (asynchronous, resetn=0):
  - es_valid=0, divider FSM=IDLE, HI=LO=0.
  - Consequences: es_to_ms_valid=0, data_sram_en=0, data_sram_wen=0, es_fwd_bus dest=0.
  - Reset asserted mid-divide aborts the divide; the instruction is lost.
- Handshake:
  - es_allowin = !es_valid || (es_ready_go && ms_allowin).
  - es_to_ms_valid = es_valid && es_ready_go.
  - When es_allowin: es_valid <= ds_to_es_valid.
  - Bus register loads only when ds_to_es_valid && es_allowin; it is held otherwise.
- Operands:
  - src1 = src1_is_sa ? {27'b0, imm[10:6]} : src1_is_pc ? pc : rs_value.
  - src2 = src2_is_imm ? sign-extended imm : src2_is_8 ? 32'd8 : rt_value.
- ALU: alu_op one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}; result is combinational through alu.
- es_result: mf_op[1] ? HI : mf_op[0] ? LO : alu_result.
  - A div instruction has gr_we=0, so its result field is don't-care.
- Divider FSM (sub-module div_iter):
  - IDLE: on es_valid && |div_op, capture |rs| and |rt| (magnitudes for div, raw values for divu) and both sign bits; count=0; go to BUSY.
  - BUSY: one restoring shift-subtract step per cycle; count increments; after step 32 go to DONE.
  - DONE: quotient/remainder valid.
    - Signed fixups: quotient negated when signs differ; remainder takes the dividend's sign.
    - es_ready_go=1.
    - On handoff (es_to_ms_valid && ms_allowin): HI <= remainder, LO <= quotient; go to IDLE.
  - DONE holds indefinitely while ms_allowin=0.
  - es_ready_go = !(|div_op) || state==DONE.
  - Timing: a div accepted at edge E0 gives es_ready_go high in cycle E0+33 at the earliest (1 cycle IDLE→BUSY, 32 steps).
- Divide by zero (pure result of the algorithm, no trap):
  - divu: LO=0xFFFFFFFF, HI=dividend.
  - div: sign fixups are applied to the unsigned result.
- MFHI/MFLO: read HI/LO combinationally. A div immediately ahead has already committed, because its commit occurs at that div's handoff edge.
- Memory interface:
  - data_sram_en = es_valid && (load_op || mem_we).
  - data_sram_wen = {4{es_valid && mem_we && ms_allowin}}; a store writes exactly once, on handoff.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rt_value.
- Forwarding:
  - es_fwd_bus dest is 0 when !es_valid.
  - res_from_mem=load_op flags a load-use hazard to ds.
  - During a div, result is don't-care because gr_we=0.
- Simultaneous events: when a handoff and an accept occur on the same edge, es_to_ms_bus carries the old instruction and the bus register takes the new one.

Decomposition:
- Shared header mycpu.h gains:
  - DS_TO_ES_BUS_WD=140, ES_TO_MS_BUS_WD=71, ES_FWD_BUS_WD=38.
  - alu_op bit indices.
  - Divider state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- Reuses the existing alu module.
- One new sub-module, div_iter:
  - Inputs: clk, resetn, start, signed_op, dividend, divisor, done_ack.
  - Outputs: busy, done, quotient, remainder.

Test Plan:
- add rs=5, rt=7, ms_allowin=1 → next cycle es_to_ms_bus result=12, gr_we=1, es_to_ms_valid=1; no stall.
- div rs=-7 (0xFFFFFFF9), rt=2 → es_ready_go low 33 cycles; after handoff LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); a following mflo yields 0xFFFFFFFD.
- divu rs=7, rt=0 → after handoff LO=0xFFFFFFFF, HI=7.
- store (mem_we=1) with ms_allowin=0 for 3 cycles, then 1 → data_sram_wen=0000 for 3 cycles, then 1111 exactly once; addr=rs+imm.
- div in DONE with ms_allowin=0 for 5 cycles → state stays DONE, HI/LO unchanged until handoff; es_allowin=0 throughout.
- resetn pulsed low at BUSY count=10 → es_valid=0, FSM IDLE, HI=LO=0 immediately (asynchronously, not waiting for an edge); the next div starts a full 33-cycle sequence.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared execute-stage constants: bus widths, ALU op bit positions,
// divider state encodings and the decode-to-execute bus layout.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 140;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_FWD_BUS_WD   = 38;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [1:0]  div_op;     // {div, divu}
        logic [1:0]  mf_op;      // {mfhi, mflo}
        logic [11:0] alu_op;
        logic        load_op;
        logic        src1_is_sa;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        src2_is_8;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } ds_to_es_t;

    function automatic logic [31:0] abs_val(input logic is_signed, input logic [31:0] v);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; alu_op is one-hot, bit positions from exe_stage_pkg.
module alu
    import exe_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
    assign sltu_res = {31'd0, alu_src1 < alu_src2};
    assign sll_res  = alu_src2 << alu_src1[4:0];
    assign srl_res  = alu_src2 >> alu_src1[4:0];
    assign sra_res  = $unsigned($signed(alu_src2) >>> alu_src1[4:0]);
    assign lui_res  = {alu_src2[15:0], 16'd0};

    assign alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
                      | ({32{alu_op[ALU_SUB]}}  & sub_res)
                      | ({32{alu_op[ALU_SLT]}}  & slt_res)
                      | ({32{alu_op[ALU_SLTU]}} & sltu_res)
                      | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[ALU_SLL]}}  & sll_res)
                      | ({32{alu_op[ALU_SRL]}}  & srl_res)
                      | ({32{alu_op[ALU_SRA]}}  & sra_res)
                      | ({32{alu_op[ALU_LUI]}}  & lui_res);

endmodule

// File: rtl/exe_stage_div_iter.sv
// 32-step restoring divider on operand magnitudes; sign fixups applied on output.
// Result holds in DONE until the owner acknowledges the handoff.
module div_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        done_ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_t  state;
    div_state_t  state_nx;
    logic [4:0]  count;
    logic [31:0] q_r;
    logic [31:0] r_r;
    logic [31:0] d_r;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] r_shift;
    logic [32:0] r_diff;
    logic        fits;

    // Quotient register doubles as the dividend shift source.
    assign r_shift = {r_r, q_r[31]};
    assign r_diff  = r_shift - {1'b0, d_r};
    assign fits    = ~r_diff[32];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            DIV_IDLE: if (start) state_nx = DIV_BUSY;
            DIV_BUSY: if (count == 5'd31) state_nx = DIV_DONE;
            DIV_DONE: if (done_ack) state_nx = DIV_IDLE;
            default:  state_nx = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: begin
                if (start) begin
                    q_r   <= abs_val(signed_op, dividend);
                    d_r   <= abs_val(signed_op, divisor);
                    r_r   <= '0;
                    neg_q <= signed_op && (dividend[31] ^ divisor[31]);
                    neg_r <= signed_op && dividend[31];
                    count <= '0;
                end
            end
            DIV_BUSY: begin
                r_r   <= fits ? r_diff[31:0] : r_shift[31:0];
                q_r   <= {q_r[30:0], fits};
                count <= count + 5'd1;
            end
            default: ;
        endcase
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = neg_q ? (~q_r + 32'd1) : q_r;
    assign remainder = neg_r ? (~r_r + 32'd1) : r_r;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand select, ALU, iterative DIV/DIVU with HI/LO,
// data-SRAM request, and the es_to_ms / forwarding buses.
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = exe_stage_pkg::DS_TO_ES_BUS_WD,
    parameter int ES_TO_MS_BUS_WD = exe_stage_pkg::ES_TO_MS_BUS_WD,
    parameter int ES_FWD_BUS_WD   = exe_stage_pkg::ES_FWD_BUS_WD
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus
);

    exe_stage_pkg::ds_to_es_t es_r;
    logic        es_valid;
    logic        es_ready_go;
    logic        is_div;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic        div_commit;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    assign is_div         = |es_r.div_op;
    assign es_ready_go    = !is_div || div_done;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk) begin
        if (ds_to_es_valid && es_allowin) es_r <= ds_to_es_bus;
    end

    assign src1 = es_r.src1_is_sa  ? {27'd0, es_r.imm[10:6]} :
                  es_r.src1_is_pc  ? es_r.pc : es_r.rs_value;
    assign src2 = es_r.src2_is_imm ? {{16{es_r.imm[15]}}, es_r.imm} :
                  es_r.src2_is_8   ? 32'd8 : es_r.rt_value;

    alu u_alu (
        .alu_op     (es_r.alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    // HI/LO commit on the div's own handoff edge, so a following MFHI/MFLO sees it.
    assign div_start  = es_valid && is_div && !div_busy && !div_done;
    assign div_commit = es_to_ms_valid && ms_allowin && is_div;

    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (es_r.div_op[1]),
        .dividend  (es_r.rs_value),
        .divisor   (es_r.rt_value),
        .done_ack  (div_commit),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (div_commit) begin
            hi <= div_rem;
            lo <= div_quot;
        end
    end

    assign es_result = es_r.mf_op[1] ? hi :
                       es_r.mf_op[0] ? lo : alu_result;

    assign data_sram_en    = es_valid && (es_r.load_op || es_r.mem_we);
    assign data_sram_wen   = {4{es_valid && es_r.mem_we && ms_allowin}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_r.rt_value;

    assign es_to_ms_bus = {es_r.load_op, es_r.gr_we, es_r.dest, es_result, es_r.pc};
    assign es_fwd_bus   = {es_r.load_op, es_result, es_r.dest & {5{es_valid}}};

endmodule

// File: tb/tb_exe_stage.sv
// Randomized scoreboard bench for exe_stage against an instruction-level reference model.
module tb_exe_stage;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [4:0]  dest;
        int unsigned k;
        logic [1:0]  div_op;
        logic [1:0]  mf_op;
        logic        load, sa, s1pc, s2imm, s2_8, gr_we, mem_we;
    } instr_t;

    typedef struct {
        logic [70:0] bus;
        logic [70:0] bus_mask;
        logic [37:0] fwd;
        logic [37:0] fwd_mask;
        logic        is_div;
        logic        is_store;
        logic        is_mem;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic         clk;
    logic         resetn;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [139:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic [37:0]  es_fwd_bus;

    exp_t        sb_q[$];
    int unsigned resident;
    int unsigned n_cmp;
    int unsigned n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic        mon_en;
    logic        ms_rand;
    logic        ms_force;

    exe_stage #(
        .DS_TO_ES_BUS_WD (140),
        .ES_TO_MS_BUS_WD (71),
        .ES_FWD_BUS_WD   (38)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .es_fwd_bus      (es_fwd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input int unsigned k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << a[4:0];
            9:  return b >> a[4:0];
            10: return $unsigned($signed(b) >>> a[4:0]);
            default: return {b[15:0], 16'd0};
        endcase
    endfunction

    function automatic void div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            m_hi = a;
            m_lo = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
    endfunction

    function automatic logic [139:0] pack(input instr_t in);
        logic [11:0] op;
        op = 12'h800 >> in.k;
        return {in.div_op, in.mf_op, op, in.load, in.sa, in.s1pc, in.s2imm, in.s2_8,
                in.gr_we, in.mem_we, in.dest, in.imm, in.rs, in.rt, in.pc};
    endfunction

    function automatic exp_t model(input instr_t in);
        exp_t e;
        logic [31:0] s1, s2, a, res, rmask;
        s1  = in.sa ? {27'd0, in.imm[10:6]} : in.s1pc ? in.pc : in.rs;
        s2  = in.s2imm ? {{16{in.imm[15]}}, in.imm} : in.s2_8 ? 32'd8 : in.rt;
        a   = alu_ref(in.k, s1, s2);
        res = in.mf_op[1] ? m_hi : in.mf_op[0] ? m_lo : a;
        e.is_div = (in.div_op != 2'b00);
        if (e.is_div) div_ref(in.div_op[1], in.rs, in.rt);
        rmask      = e.is_div ? 32'd0 : 32'hFFFF_FFFF;
        e.bus      = {in.load, in.gr_we, in.dest, res, in.pc};
        e.bus_mask = {7'h7F, rmask, 32'hFFFF_FFFF};
        e.fwd      = {in.load, res, in.dest};
        e.fwd_mask = {1'b1, rmask, 5'h1F};
        e.is_store = in.mem_we;
        e.is_mem   = in.load | in.mem_we;
        e.addr     = a;
        e.wdata    = in.rt;
        return e;
    endfunction

    function automatic instr_t base(input int unsigned k, input logic [31:0] rs, input logic [31:0] rt);
        instr_t i;
        i = '{pc: 32'hBFC0_0100, rs: rs, rt: rt, imm: 16'h0, dest: 5'd3, k: k,
              div_op: 2'b00, mf_op: 2'b00, load: 1'b0, sa: 1'b0, s1pc: 1'b0,
              s2imm: 1'b0, s2_8: 1'b0, gr_we: 1'b1, mem_we: 1'b0};
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int unsigned kind;
        kind = $urandom_range(0, 9);
        i = base($urandom_range(0, 11), $urandom, $urandom);
        i.pc   = $urandom & 32'hFFFF_FFFC;
        i.imm  = 16'($urandom);
        i.dest = 5'($urandom);
        if ($urandom_range(0, 3) == 0) i.rt = $urandom_range(0, 5);
        if ($urandom_range(0, 3) == 0) i.rs = $urandom_range(0, 40) - 20;
        case (kind)
            0, 1, 2, 3, 4: begin
                i.sa    = ($urandom_range(0, 3) == 0);
                i.s1pc  = ($urandom_range(0, 3) == 0);
                i.s2imm = ($urandom_range(0, 2) == 0);
                i.s2_8  = ($urandom_range(0, 3) == 0);
            end
            5: begin i.k = 0; i.s2imm = 1'b1; i.load = 1'b1; end
            6: begin i.k = 0; i.s2imm = 1'b1; i.mem_we = 1'b1; i.gr_we = 1'b0; end
            7, 8: begin i.div_op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01; i.gr_we = 1'b0; end
            default: i.mf_op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        endcase
        return i;
    endfunction

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    endtask

    task automatic issue(input instr_t in);
        logic acc;
        int unsigned waits;
        waits = 0;
        @(negedge clk);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = pack(in);
        #1 acc = es_allowin;
        @(posedge clk);
        while (!acc) begin
            waits++;
            if (waits > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got es_allowin=0 for %0d cycles required 1", waits);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
            #1 acc = es_allowin;
            @(posedge clk);
        end
        sb_q.push_back(model(in));
    endtask

    task automatic idle(input int unsigned n);
        logic [159:0] g;
        repeat (n) begin
            @(negedge clk);
            g = {$urandom, $urandom, $urandom, $urandom, $urandom};
            ds_to_es_valid = 1'b0;
            ds_to_es_bus   = g[139:0];
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            ms_allowin = ms_rand ? ($urandom_range(0, 3) != 0) : ms_force;
        end
    end

    initial begin : monitor
        exp_t h;
        logic go;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    chk("empty_valid",   es_to_ms_valid, 0);
                    chk("empty_allowin", es_allowin, 1);
                    chk("empty_en",      data_sram_en, 0);
                    chk("empty_wen",     data_sram_wen, 0);
                    chk("empty_fwd_dst", es_fwd_bus[4:0], 0);
                end else begin
                    h  = sb_q[0];
                    go = !h.is_div || (resident >= 33);
                    chk("es_to_ms_valid", es_to_ms_valid, go);
                    chk("es_allowin",     es_allowin, go && ms_allowin);
                    chk("sram_en",        data_sram_en, h.is_mem);
                    chk("sram_wen",       data_sram_wen, {4{h.is_store && ms_allowin}});
                    chk("fwd_bus",        es_fwd_bus & h.fwd_mask, h.fwd & h.fwd_mask);
                    if (go && ms_allowin) begin
                        chk("es_to_ms_bus", es_to_ms_bus & h.bus_mask, h.bus & h.bus_mask);
                        if (h.is_mem) chk("sram_addr", data_sram_addr, h.addr);
                        if (h.is_store) chk("sram_wdata", data_sram_wdata, h.wdata);
                        void'(sb_q.pop_front());
                        resident = 0;
                    end else begin
                        resident++;
                    end
                end
            end
        end
    end

    initial begin
        instr_t i;
        n_cmp = 0; n_fail = 0; resident = 0;
        m_hi = '0; m_lo = '0;
        mon_en = 1'b0; ms_rand = 1'b0; ms_force = 1'b1;
        ms_allowin = 1'b1;
        resetn = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus = '0;
        #22;
        chk("rst_valid",   es_to_ms_valid, 0);
        chk("rst_en",      data_sram_en, 0);
        chk("rst_wen",     data_sram_wen, 0);
        chk("rst_fwd_dst", es_fwd_bus[4:0], 0);
        chk("rst_allowin", es_allowin, 1);
        @(negedge clk);
        #3 resetn = 1'b1;
        mon_en = 1'b1;

        // add 5 + 7
        issue(base(0, 32'd5, 32'd7));
        // div -7 / 2, then read back LO and HI
        i = base(0, 32'hFFFF_FFF9, 32'd2); i.div_op = 2'b10; i.gr_we = 1'b0;
        issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b01; issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b10; issue(i);
        // divu 7 / 0
        i = base(0, 32'd7, 32'd0); i.div_op = 2'b01; i.gr_we = 1'b0;
        issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b01; issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b10; issue(i);
        idle(1);
        // store held by ms for several cycles
        ms_force = 1'b0;
        i = base(0, 32'h0000_1000, 32'hCAFE_F00D); i.imm = 16'h0010;
        i.s2imm = 1'b1; i.mem_we = 1'b1; i.gr_we = 1'b0;
        issue(i);
        idle(3);
        ms_force = 1'b1;
        idle(3);
        // div parked in DONE while ms stalls
        ms_force = 1'b0;
        i = base(0, 32'd100, 32'hFFFF_FFF9); i.div_op = 2'b10; i.gr_we = 1'b0;
        issue(i);
        idle(40);
        ms_force = 1'b1;
        i = base(0, 0, 0); i.mf_op = 2'b01; issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b10; issue(i);
        // reset in the middle of a divide
        i = base(0, 32'd1000, 32'd3); i.div_op = 2'b01; i.gr_we = 1'b0;
        issue(i);
        idle(1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("arst_valid",   es_to_ms_valid, 0);
        chk("arst_en",      data_sram_en, 0);
        chk("arst_fwd_dst", es_fwd_bus[4:0], 0);
        chk("arst_allowin", es_allowin, 1);
        sb_q.delete();
        resident = 0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        #3 resetn = 1'b1;
        i = base(0, 0, 0); i.mf_op = 2'b10; issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b01; issue(i);
        i = base(0, 32'd1000, 32'd3); i.div_op = 2'b01; i.gr_we = 1'b0;
        issue(i);
        i = base(0, 0, 0); i.mf_op = 2'b01; issue(i);

        // randomized traffic
        ms_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            issue(rand_instr());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        for (int w = 0; w < 1000 && sb_q.size() != 0; w++) @(negedge clk);
        chk("drain_empty", sb_q.size(), 0);
        finish_run();
    end

endmodule
